sequence_generator: RTL and testbench
=====================================

Name: sequence_generator

Overview:
Serial transmitter that emits a captured WIDTH-bit pattern MSB-first on a 1-bit line, repeated a programmed number of times with an optional idle gap between repetitions. It is the source side of the serial bit stream consumed by sequence_detector; its output drives the detector's in port directly. Start is a valid/ready handshake, and completion is signalled by a one-cycle done pulse.

Parameters:
WIDTH, 4, pattern length in bits; legal range 2..32.
CNT_W, 8, width of the repetition-count input.
GAP, 0, idle cycles inserted between consecutive repetitions (0 = back-to-back).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset; one clock, reset is synchronous and active-low
start_valid  input  1  request to begin a transmission
start_ready  output  1  high only in IDLE with rst high
pattern  input  WIDTH  bits to send; sampled only on handshake
reps  input  CNT_W  repetition count; sampled on handshake; 0 is treated as 1
abort  input  1  cancels an in-progress transmission
out  output  1  serial data bit
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse after the last bit of the last repetition

Behaviour:
- Reset (rst low at an edge): state to IDLE; out=0, out_valid=0, busy=0, done=0. start_ready is 0 while rst is low.
- States: IDLE, SHIFT, GAP.
- IDLE: start_ready=1.
  - On start_valid and start_ready: capture pattern into the shift register and reps (0 becomes 1) into rep_left; bit_cnt=0; go to SHIFT.
  - In the next cycle, out=pattern[WIDTH-1] and out_valid=1, so latency from handshake to first bit is 1 cycle.
- SHIFT: one bit per cycle, MSB first; out_valid=1 and busy=1.
  - At bit_cnt=WIDTH-1 with rep_left=1: go to IDLE; done=1 for exactly the following cycle.
  - At bit_cnt=WIDTH-1 with rep_left>1: decrement rep_left and reload the captured pattern. Go to GAP if GAP>0, otherwise stay in SHIFT and emit the next repetition's MSB in the next cycle with no bubble.
- GAP: out=0, out_valid=0, busy=1 for exactly GAP cycles, then SHIFT.
- Output timing: done, out and out_valid are registered. During the done cycle, state is IDLE and start_ready=1, so a new start can be accepted in that cycle.
- Total transmission: reps*WIDTH + (reps-1)*GAP cycles from first bit to last bit.
- Abort:
  - Sampled high in SHIFT or GAP: go to IDLE next cycle with out=0 and out_valid=0; done is not pulsed.
  - Ignored in IDLE. If abort and start_valid are both high in IDLE, the start is accepted.
- Stable inputs: pattern and reps changing during SHIFT or GAP has no effect.
- start_valid held high: a new transmission is accepted only in IDLE.
- Reset mid-transmission: reset values on the next edge; no done pulse.
- out=0 whenever out_valid=0.
- Counter widths:
  - bit_cnt: max(1, clog2(WIDTH)).
  - gap_cnt: max(1, clog2(GAP+1)).
  - rep_left: CNT_W.
  - No counter wraps.

Decomposition:
- Package seq_gen_pkg holds the state enum typedef (IDLE, SHIFT, GAP) and the default WIDTH, CNT_W and GAP constants.
- One sub-module is natural: seq_shift_reg, a WIDTH-bit parallel-load, MSB-out shift register with load and shift enables. The FSM and counters stay in the top level.

Test Plan:
1. Reset, then start with pattern=4'b1011, reps=1 -> out_valid high for 4 cycles starting 1 cycle after the handshake; out sequence is 1,0,1,1; done pulses once in the cycle after the last bit; busy=0 afterwards.
2. pattern=1011, reps=2, GAP=0, with out looped into sequence_detector in -> stream 1,0,1,1,1,0,1,1 with no bubble; detector detected asserts twice; done pulses once after bit 8.
3. pattern=1011, reps=3, GAP=2 -> each 4-bit burst is followed by 2 cycles of out_valid=0 and out=0 (no gap after the last burst); 16 cycles from first bit to last bit.
4. reps=0 -> behaves as reps=1; exactly 4 bits are sent.
5. abort asserted during the 3rd bit of reps=2 -> IDLE next cycle; out_valid=0; no done pulse; start_ready=1.
6. rst driven low mid-SHIFT for 1 cycle -> all outputs 0 next cycle. start_valid held high across the done cycle -> back-to-back accept, with the first bit of the next transmission in the cycle after done.

Source files
------------

// File: rtl/seq_gen_pkg.sv
// Shared types and default parameters for the serial pattern transmitter.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } seq_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_GAP   = 0;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load shift register presenting its MSB; zeros shift in from the LSB.
module seq_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst)       r_data <= '0;
    else if (i_load)  r_data <= i_data;
    else if (i_shift) r_data <= {r_data[WIDTH-2:0], 1'b0};
  end

  assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Sends a captured pattern MSB-first, repeated reps times with an optional idle gap.
//   state   | meaning
//   S_IDLE  | waiting for a start handshake
//   S_SHIFT | emitting one pattern bit per cycle
//   S_GAP   | idle gap between repetitions
module sequence_generator
  import seq_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] reps,
  input  logic             abort,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int GC_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(WIDTH - 1);
  localparam logic [BC_W-1:0]  BC_ONE  = BC_W'(1);
  localparam logic [GC_W-1:0]  GC_LOAD = GC_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [GC_W-1:0]  GC_ONE  = GC_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE = CNT_W'(1);

  seq_state_t       r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_pattern,  w_pattern_nxt;
  logic [CNT_W-1:0] r_rep_left, w_rep_nxt;
  logic [BC_W-1:0]  r_bit_cnt,  w_bit_nxt;
  logic [GC_W-1:0]  r_gap_cnt,  w_gap_nxt;
  logic             r_done,     w_done_nxt;
  logic             w_load, w_shift, w_msb;
  logic [WIDTH-1:0] w_load_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_pattern  <= '0;
      r_rep_left <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pattern  <= w_pattern_nxt;
      r_rep_left <= w_rep_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_gap_cnt  <= w_gap_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pattern_nxt = r_pattern;
    w_rep_nxt     = r_rep_left;
    w_bit_nxt     = r_bit_cnt;
    w_gap_nxt     = r_gap_cnt;
    w_done_nxt    = 1'b0;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_pattern_nxt = pattern;
          w_rep_nxt     = (reps == '0) ? REP_ONE : reps;
          w_bit_nxt     = '0;
          w_load        = 1'b1;
          w_state_nxt   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_bit_cnt == BC_LAST) begin
          if (r_rep_left <= REP_ONE) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            // reload the captured copy; inputs may have moved since the handshake
            w_rep_nxt = r_rep_left - REP_ONE;
            w_bit_nxt = '0;
            w_load    = 1'b1;
            if (GAP > 0) begin
              w_state_nxt = S_GAP;
              w_gap_nxt   = GC_LOAD;
            end
          end
        end else begin
          w_bit_nxt = r_bit_cnt + BC_ONE;
          w_shift   = 1'b1;
        end
      end
      S_GAP: begin
        if (abort)                 w_state_nxt = S_IDLE;
        else if (r_gap_cnt == '0)  w_state_nxt = S_SHIFT;
        else                       w_gap_nxt   = r_gap_cnt - GC_ONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_load_data = (r_state == S_IDLE) ? pattern : r_pattern;

  seq_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_load_data),
    .o_msb   (w_msb)
  );

  assign start_ready = (r_state == S_IDLE) && rst;
  assign out_valid   = (r_state == S_SHIFT);
  assign out         = w_msb && out_valid;
  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench for sequence_generator: one instance with GAP=0 and one with GAP=2.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sv0 = 1'b0, sv2 = 1'b0, abort = 1'b0;
  logic [3:0] pattern = '0;
  logic [7:0] reps = '0;
  logic       sel = 1'b0;

  logic rdy0, out0, ov0, busy0, done0;
  logic rdy2, out2, ov2, busy2, done2;
  logic rdy_s, out_s, ov_s, busy_s, done_s;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequence_generator #(.WIDTH(4), .CNT_W(8), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start_valid(sv0), .start_ready(rdy0),
    .pattern(pattern), .reps(reps), .abort(abort),
    .out(out0), .out_valid(ov0), .busy(busy0), .done(done0)
  );

  sequence_generator #(.WIDTH(4), .CNT_W(8), .GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(rdy2),
    .pattern(pattern), .reps(reps), .abort(abort),
    .out(out2), .out_valid(ov2), .busy(busy2), .done(done2)
  );

  assign rdy_s  = sel ? rdy2  : rdy0;
  assign out_s  = sel ? out2  : out0;
  assign ov_s   = sel ? ov2   : ov0;
  assign busy_s = sel ? busy2 : busy0;
  assign done_s = sel ? done2 : done0;

  typedef struct {
    bit         sel;
    logic [3:0] pat;
    logic [7:0] reps;
    bit         ab;
    int         len;
    logic [31:0] ev;
    logic [31:0] eo;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_tx(input vec_t v);
    sel = v.sel;
    @(negedge clk);
    chk("ready_before", {31'd0, rdy_s}, 32'd1);
    pattern = v.pat;
    reps    = v.reps;
    abort   = v.ab;
    if (v.sel) sv2 = 1'b1; else sv0 = 1'b1;
    @(posedge clk);
    #1;
    sv0 = 1'b0; sv2 = 1'b0; abort = 1'b0;
    pattern = ~v.pat;
    reps    = 8'd5;
    for (int k = 0; k < v.len; k++) begin
      @(negedge clk);
      chk("out_valid", {31'd0, ov_s},   {31'd0, v.ev[v.len-1-k]});
      chk("out",       {31'd0, out_s},  {31'd0, v.eo[v.len-1-k]});
      chk("busy",      {31'd0, busy_s}, 32'd1);
      chk("no_early_done", {31'd0, done_s}, 32'd0);
    end
    @(negedge clk);
    chk("done_pulse",  {31'd0, done_s}, 32'd1);
    chk("idle_valid",  {31'd0, ov_s},   32'd0);
    chk("idle_busy",   {31'd0, busy_s}, 32'd0);
    chk("ready_done",  {31'd0, rdy_s},  32'd1);
    @(negedge clk);
    chk("done_single", {31'd0, done_s}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 4'b1011, 8'd1, 0, 4,  32'b1111,             32'b1011};
    tbl[1] = '{0, 4'b1011, 8'd2, 0, 8,  32'b11111111,         32'b10111011};
    tbl[2] = '{1, 4'b1011, 8'd3, 0, 16, 32'b1111001111001111, 32'b1011001011001011};
    tbl[3] = '{0, 4'b0110, 8'd0, 0, 4,  32'b1111,             32'b0110};
    tbl[4] = '{0, 4'b1000, 8'd1, 1, 4,  32'b1111,             32'b1000};
    tbl[5] = '{1, 4'b0101, 8'd2, 0, 10, 32'b1111001111,       32'b0101000101};

    // reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_valid", {31'd0, ov0},  32'd0);
    chk("rst_busy",  {31'd0, busy0}, 32'd0);
    chk("rst_done",  {31'd0, done0}, 32'd0);
    chk("rst_out",   {31'd0, out0},  32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, rdy0}, 32'd1);

    for (int i = 0; i < 6; i++) run_tx(tbl[i]);

    // abort during the third bit of a two-repetition transfer
    sel = 1'b0;
    @(negedge clk);
    pattern = 4'b1011; reps = 8'd2; sv0 = 1'b1;
    @(posedge clk); #1 sv0 = 1'b0;
    @(negedge clk); chk("ab_bit0", {31'd0, out0}, 32'd1);
    @(negedge clk); chk("ab_bit1", {31'd0, out0}, 32'd0);
    @(negedge clk); chk("ab_bit2", {31'd0, out0}, 32'd1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("ab_valid", {31'd0, ov0},   32'd0);
    chk("ab_out",   {31'd0, out0},  32'd0);
    chk("ab_busy",  {31'd0, busy0}, 32'd0);
    chk("ab_done",  {31'd0, done0}, 32'd0);
    chk("ab_ready", {31'd0, rdy0},  32'd1);
    @(negedge clk);
    chk("ab_no_done", {31'd0, done0}, 32'd0);

    // synchronous reset in the middle of SHIFT
    pattern = 4'b1011; reps = 8'd2; sv0 = 1'b1;
    @(posedge clk); #1 sv0 = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("mr_busy_pre", {31'd0, busy0}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_valid", {31'd0, ov0},   32'd0);
    chk("mr_busy",  {31'd0, busy0}, 32'd0);
    chk("mr_done",  {31'd0, done0}, 32'd0);
    chk("mr_ready", {31'd0, rdy0},  32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_no_done", {31'd0, done0}, 32'd0);
    chk("mr_ready2",  {31'd0, rdy0},  32'd1);

    // start_valid held high: back-to-back accept in the done cycle
    pattern = 4'b1011; reps = 8'd1; sv0 = 1'b1;
    @(posedge clk); #1 pattern = 4'b0110;
    begin
      logic [3:0] exp_a;
      exp_a = 4'b1011;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("b2b_a_out", {31'd0, out0}, {31'd0, exp_a[3-k]});
        chk("b2b_a_rdy", {31'd0, rdy0}, 32'd0);
      end
    end
    @(negedge clk);
    chk("b2b_done",  {31'd0, done0}, 32'd1);
    chk("b2b_ready", {31'd0, rdy0},  32'd1);
    @(posedge clk); #1 sv0 = 1'b0;
    begin
      logic [3:0] exp_b;
      exp_b = 4'b0110;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        chk("b2b_b_valid", {31'd0, ov0},  32'd1);
        chk("b2b_b_out",   {31'd0, out0}, {31'd0, exp_b[3-k]});
      end
    end
    @(negedge clk);
    chk("b2b_done2", {31'd0, done0}, 32'd1);
    @(negedge clk);
    chk("b2b_idle",  {31'd0, busy0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
